tt_add_accum: RTL and testbench
===============================

Name: tt_add_accum

Overview:
Parametrised successor to the registered nibble adder used on the Tiny Tapeout user tile.
- Adds two W-bit operands under a valid qualifier.
- In ACC modes, keeps a running ACC_W-bit sum with optional saturation, a sticky overflow flag and a sample counter.
- Sits between the tile's dedicated input pins and the output pins; the top-level maps ui_in/uio_in/uo_out onto the ports below.

Parameters:
- W, 4, operand width in bits (>=2).
- ACC_W, 8, accumulator/result width in bits (must be >= W+1).
- CNT_W, 4, sample-counter width in bits.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are valid this cycle.
- op_a  input  W  operand A, unsigned.
- op_b  input  W  operand B, unsigned.
- mode  input  2  00 ADD, 01 ACC_WRAP, 10 ACC_SAT, 11 SUB.
- clear  input  1  synchronous clear of accumulator, counter and overflow flag.
- out_valid  output  1  result is valid; one-cycle pulse.
- result  output  ACC_W  registered result.
- overflow  output  1  sticky overflow/underflow flag.
- count  output  CNT_W  number of accepted ACC_* samples since the last clear.

Behaviour:
- Reset (rst_n low, async):
  - result=0, out_valid=0, overflow=0, count=0, internal acc=0.
  - Deassertion is sampled on clk; the first operation is accepted on the first rising edge with rst_n high.
- Latency:
  - Exactly 1 cycle.
  - in_valid sampled high at edge N gives out_valid=1 and the new result after edge N; out_valid is 0 after edge N+1 unless in_valid is high again.
  - Back-to-back in_valid every cycle is supported; no stall and no ready signal.
- sum = op_a + op_b, computed at W+1 bits and zero-extended to ACC_W.
- ADD (00):
  - result <= sum.
  - acc, count and overflow are untouched.
- ACC_WRAP (01):
  - acc_next = acc + sum, modulo 2^ACC_W.
  - If the true sum >= 2^ACC_W, set overflow.
  - result <= acc_next; count <= count+1.
- ACC_SAT (10):
  - acc_next = min(acc + sum, 2^ACC_W-1).
  - If clamping occurred, set overflow.
  - result <= acc_next; count <= count+1.
- SUB (11):
  - result <= (op_a - op_b) modulo 2^ACC_W, two's complement sign-extended from W+1 bits.
  - If op_a < op_b, set overflow.
  - acc and count are untouched.
- count:
  - Wraps from 2^CNT_W-1 to 0.
  - Wrap does not affect overflow.
- overflow:
  - Sticky; cleared only by clear or reset.
- clear:
  - clear without in_valid: acc=0, count=0, overflow=0, result=0; out_valid stays 0.
  - clear with in_valid in an ACC mode: the clear applies first, so acc_next = 0 + sum, count=1, and overflow reflects only this operation. result=sum, out_valid=1.
  - clear with in_valid in ADD/SUB: acc=0, count=0, overflow = this operation's flag; result is per the mode.
- No in_valid and no clear: all registers hold; out_valid=0.
- A mode change between ACC_WRAP and ACC_SAT keeps the same acc.
- Reset asserted mid-stream: everything returns to reset values immediately, without waiting for a clock edge.

Test Plan:
1. Reset then ADD: W=4, a=7, b=9, in_valid one cycle -> next cycle result=16, out_valid=1, overflow=0; the following cycle out_valid=0 and result holds 16.
2. ACC_WRAP stream: 18 samples of a=15, b=15 (30 each) -> result runs 30, 60, …, 240, then 270 mod 256=14 with overflow=1 on sample 9; count wraps 15→0 at sample 16 and reads 2 after sample 18.
3. ACC_SAT: 9 samples of a=15, b=15 -> result sticks at 255 from sample 9 onward; overflow=1 from sample 9; count=9.
4. SUB: a=3, b=5 -> result=0xFE, overflow=1. Then clear alone -> result=0, overflow=0, out_valid=0.
5. Simultaneous clear+in_valid in ACC_WRAP with acc=200: a=1, b=2 -> result=3, count=1, overflow=0.
6. Assert rst_n low asynchronously mid-stream (between edges, during ACC) -> outputs 0 immediately. After release, ACC with a=1, b=1 -> result=2, count=1.

Source files
------------

// File: rtl/tt_add_accum.sv
// rtl/tt_add_accum.sv - registered add/subtract unit with wrapping or saturating accumulator
//
// Purpose:
//   Adds or subtracts two unsigned W-bit operands whenever in_valid is high.
//   The two ACC modes also keep a running ACC_W-bit total, a sample counter
//   and a sticky overflow flag. The result appears one cycle after the
//   operands are accepted.
//
// Parameters:
//   W      operand width (>= 2)
//   ACC_W  result/accumulator width (>= W+1)
//   CNT_W  sample counter width
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   op_a/op_b/mode are valid this cycle
//   op_a       operand A, unsigned
//   op_b       operand B, unsigned
//   mode       00 ADD, 01 ACC_WRAP, 10 ACC_SAT, 11 SUB
//   clear      synchronous clear of accumulator, counter and overflow
//   out_valid  one-cycle pulse, result updated
//   result     registered result
//   overflow   sticky overflow/underflow flag
//   count      ACC samples accepted since the last clear (wraps)

module tt_add_accum #(
    parameter int W     = 4,
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             out_valid,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] MODE_ADD      = 2'b00;
    localparam logic [1:0] MODE_ACC_WRAP = 2'b01;
    localparam logic [1:0] MODE_ACC_SAT  = 2'b10;
    localparam logic [1:0] MODE_SUB      = 2'b11;

    logic [ACC_W-1:0] acc_q;

    logic [W:0]       sum_w;
    logic [W:0]       diff_w;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0] diff_ext;

    logic [ACC_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic             ovf_base;
    logic [ACC_W:0]   acc_plus;

    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic [ACC_W-1:0] op_result;
    logic             op_flag;
    logic             is_acc;

    // Operands are zero-extended by one bit so the carry of the add and the
    // borrow of the subtract both land in bit W.
    assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_w = {1'b0, op_a} - {1'b0, op_b};

    assign sum_ext = ACC_W'(sum_w);

    // diff_w is a W+1 bit two's complement value; replicate its top bit
    // into the wider result.
    always_comb begin
        diff_ext = '0;
        for (int i = 0; i < ACC_W; i++) begin
            diff_ext[i] = (i <= W) ? diff_w[i] : diff_w[W];
        end
    end

    // A clear arriving together with an operation takes effect first, so the
    // operation sees an empty accumulator, zero count and a clean flag.
    assign acc_base = clear ? '0 : acc_q;
    assign cnt_base = clear ? '0 : count;
    assign ovf_base = clear ? 1'b0 : overflow;

    // One extra bit keeps the true sum so carry-out detects wrap/saturation.
    assign acc_plus = {1'b0, acc_base} + {1'b0, sum_ext};

    assign is_acc = (mode == MODE_ACC_WRAP) || (mode == MODE_ACC_SAT);

    always_comb begin
        acc_next  = acc_base;
        op_result = sum_ext;
        op_flag   = 1'b0;
        case (mode)
            MODE_ADD: begin
                op_result = sum_ext;
            end
            MODE_ACC_WRAP: begin
                acc_next  = acc_plus[ACC_W-1:0];
                op_flag   = acc_plus[ACC_W];
                op_result = acc_plus[ACC_W-1:0];
            end
            MODE_ACC_SAT: begin
                if (acc_plus[ACC_W]) begin
                    acc_next = '1;
                    op_flag  = 1'b1;
                end else begin
                    acc_next = acc_plus[ACC_W-1:0];
                end
                op_result = acc_next;
            end
            MODE_SUB: begin
                op_result = diff_ext;
                // Borrow out of the zero-extended subtract means op_a < op_b.
                op_flag   = diff_w[W];
            end
            default: begin
                op_result = sum_ext;
            end
        endcase
    end

    assign cnt_next = is_acc ? (cnt_base + CNT_W'(1)) : cnt_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            result    <= op_result;
            acc_q     <= acc_next;
            count     <= cnt_next;
            overflow  <= ovf_base | op_flag;
        end else if (clear) begin
            out_valid <= 1'b0;
            result    <= '0;
            acc_q     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tt_add_accum.sv
// tb/tb_tt_add_accum.sv - randomized and directed self-checking bench for tt_add_accum

module tb_tt_add_accum;

    localparam int W     = 4;
    localparam int ACC_W = 8;
    localparam int CNT_W = 4;
    localparam int ACC_MOD = 1 << ACC_W;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [1:0]       mode;
    logic             clear;
    logic             out_valid;
    logic [ACC_W-1:0] result;
    logic             overflow;
    logic [CNT_W-1:0] count;

    tt_add_accum #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .mode      (mode),
        .clear     (clear),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, plain integers.
    int m_acc = 0;
    int m_cnt = 0;
    int m_ovf = 0;
    int m_res = 0;
    int m_vld = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_ovf = 0; m_res = 0; m_vld = 0;
    endtask

    task automatic model_step(input bit v, input bit c, input int m, input int a, input int b);
        int t;
        if (c) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0;
        end
        if (v) begin
            m_vld = 1;
            case (m)
                0: m_res = a + b;
                1: begin
                    t = m_acc + a + b;
                    if (t >= ACC_MOD) m_ovf = 1;
                    m_acc = t % ACC_MOD;
                    m_cnt = (m_cnt + 1) % CNT_MOD;
                    m_res = m_acc;
                end
                2: begin
                    t = m_acc + a + b;
                    if (t > ACC_MOD - 1) begin
                        m_ovf = 1;
                        t = ACC_MOD - 1;
                    end
                    m_acc = t;
                    m_cnt = (m_cnt + 1) % CNT_MOD;
                    m_res = m_acc;
                end
                default: begin
                    if (a < b) m_ovf = 1;
                    m_res = ((a - b) + ACC_MOD) % ACC_MOD;
                end
            endcase
        end else if (c) begin
            m_res = 0;
            m_vld = 0;
        end else begin
            m_vld = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, int'(out_valid), m_vld);
        check({tag, ".result"},    int'(result),    m_res);
        check({tag, ".overflow"},  int'(overflow),  m_ovf);
        check({tag, ".count"},     int'(count),     m_cnt);
    endtask

    task automatic cyc(input string tag, input bit v, input bit c, input int m, input int a, input int b);
        in_valid = v;
        clear    = c;
        mode     = 2'(m);
        op_a     = W'(a);
        op_b     = W'(b);
        @(posedge clk);
        model_step(v, c, m, a, b);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; mode = 2'b00; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        rst_n = 1'b1;

        // 1: ADD then idle
        cyc("add", 1, 0, 0, 7, 9);
        check("add.result16", int'(result), 16);
        cyc("add_idle", 0, 0, 0, 0, 0);
        check("add_idle.hold16", int'(result), 16);

        // 2: wrapping accumulate, counter wrap
        cyc("clr0", 0, 1, 0, 0, 0);
        for (int i = 1; i <= 18; i++) begin
            cyc("wrap", 1, 0, 1, 15, 15);
            if (i == 9) begin
                check("wrap9.result", int'(result), 14);
                check("wrap9.overflow", int'(overflow), 1);
            end
            if (i == 16) check("wrap16.count", int'(count), 0);
        end
        check("wrap18.count", int'(count), 2);

        // 3: saturating accumulate
        cyc("clr1", 0, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) cyc("sat", 1, 0, 2, 15, 15);
        check("sat9.result", int'(result), 255);
        check("sat9.count", int'(count), 9);

        // 4: SUB underflow, then clear alone
        cyc("sub", 1, 0, 3, 3, 5);
        check("sub.result", int'(result), 8'hFE);
        cyc("clr_alone", 0, 1, 0, 0, 0);
        check("clr_alone.overflow", int'(overflow), 0);

        // 5: clear together with an ACC_WRAP op while acc=200
        for (int i = 0; i < 6; i++) cyc("to200", 1, 0, 1, 15, 15);
        cyc("to200", 1, 0, 1, 10, 10);
        check("to200.result", int'(result), 200);
        cyc("clr_op", 1, 1, 1, 1, 2);
        check("clr_op.result", int'(result), 3);
        check("clr_op.count", int'(count), 1);

        // 6: asynchronous reset between edges mid-stream
        cyc("pre_rst", 1, 0, 1, 5, 6);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("post_rst", 1, 0, 1, 1, 1);
        check("post_rst.result", int'(result), 2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0,
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)));
        end

        in_valid = 1'b0;
        clear    = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
